display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Time-shares the 8-digit seven-segment display among up to NUM_SRC data sources: game score, game state/debug, FFT status and note view.
- Sits between the per-source 32-bit hex words and the display driver's data_in.
- Rotates among valid sources automatically or on a user "next" pulse.
- Grants temporary overlays, such as a score popup, to requesters through a req/ack/done handshake.

Parameters:
- NUM_SRC, 4: number of sources/overlay requesters, 2..8.
- DWELL_CYCLES, 100_000_000: cycles each source is shown in auto mode (1 s at 100 MHz).
- OVERLAY_CYCLES, 200_000_000: maximum overlay duration in cycles.
- CNT_W, 28: width of the dwell and overlay counters; must hold max(DWELL_CYCLES, OVERLAY_CYCLES).

Ports:
- clk_in, input, 1: system clock (100 MHz domain).
- rst_in, input, 1: reset, asynchronous, active-high.
- src_data_in, input, 32*NUM_SRC: source i word at [32*i+31:32*i], 8 hex digits, MSB first.
- src_valid_in, input, NUM_SRC: source i currently has displayable data.
- auto_in, input, 1: 1 = auto-rotate; 0 = manual.
- next_in, input, 1: single-cycle pulse that advances to the next valid source (already debounced and edge-detected).
- ovl_req_in, input, NUM_SRC: overlay request levels.
- ovl_ack_out, output, NUM_SRC: one-cycle pulse when an overlay is granted.
- ovl_done_out, output, NUM_SRC: one-cycle pulse when an overlay ends.
- seg_data_out, output, 32: word for the display driver.
- blank_out, output, 8: per-digit blank mask; 1 = blanked; bit 7 = leftmost digit.
- active_src_out, output, $clog2(NUM_SRC): index currently shown.
- overlay_active_out, output, 1: high while in OVERLAY.

Behaviour:
- Reset (async, active-high) sets all outputs and state immediately:
  - state IDLE, cur = 0, counters 0, all armed bits 1.
  - seg_data_out = 0, blank_out = 8'hFF, all acks/dones 0, active_src_out = 0, overlay_active_out = 0.
- All outputs are registered. seg_data_out follows the selected src_data_in with 1-cycle latency.
- "Advance" means a cyclic search from cur+1 for the next valid source, wrapping at NUM_SRC-1 -> 0. If cur is the only valid source, cur is unchanged. The dwell counter always clears to 0 on advance.
- IDLE:
  - blank_out = FF, seg_data_out = 0.
  - When any src_valid_in is high, go to SHOW with cur = lowest valid index.
- SHOW:
  - seg_data_out <= src_data[cur], blank_out = 00.
  - If src_valid_in[cur] drops, advance; if no source is valid, go to IDLE next cycle.
  - In auto mode the dwell counter counts; reaching DWELL_CYCLES-1 triggers an advance. In manual mode the counter holds at 0.
  - next_in advances in either mode. next_in and dwell expiry in the same cycle cause a single advance.
- Overlay grant (SHOW or IDLE):
  - Candidates are requesters with ovl_req_in[i] = 1 and armed[i] = 1; the lowest index wins.
  - On grant: ovl_ack_out[i] pulses, save cur, ovl_src = i, overlay counter = 0, go to OVERLAY.
  - A grant takes priority over next_in and dwell expiry in the same cycle; those events are dropped.
- OVERLAY:
  - seg_data_out <= src_data[ovl_src] regardless of src_valid_in. blank_out = 00. overlay_active_out = 1. active_src_out = ovl_src.
  - next_in is ignored and other requests wait; there is no preemption.
  - Ends when the counter reaches OVERLAY_CYCLES-1 or when ovl_req_in[ovl_src] drops (early release).
  - On end:
    - ovl_done_out[ovl_src] pulses and armed[ovl_src] clears.
    - Return to SHOW with saved cur and dwell restarted at 0.
    - If saved cur is no longer valid, advance; if no source is valid, go to IDLE.
- Armed bits: armed[i] is set whenever ovl_req_in[i] is low. A requester must deassert for at least 1 cycle before it can be granted again, which prevents a held request from re-grabbing the display.
- Reset mid-overlay: return to reset values; no done pulse is emitted.
- At most one ack or done bit is high in any cycle, and ack and done never assert in the same cycle.

Optional Feature:
DISPLAY_SCHEDULER_BLINK_EN:
- Defined:
  - Adds parameter BLINK_CYCLES (default 25_000_000).
  - During OVERLAY, blank_out toggles between 8'h00 and 8'hFF every BLINK_CYCLES. It starts at 00 on grant and is forced to 00 on exit.
- Undefined: blank_out is 00 throughout OVERLAY and no blink counter is synthesized.

Test Plan:
All scenarios use bench parameters NUM_SRC=4, DWELL_CYCLES=8, OVERLAY_CYCLES=20.
- Reset/idle: assert rst_in mid-cycle -> outputs go to reset values immediately with blank_out=FF. Release with src_valid=0000 -> stays IDLE, seg_data_out=0.
- Auto rotation: src_valid=1011, auto_in=1, data_i=32'h1111_1111*i -> active_src sequence 0,1,3,0 with 8 cycles each. seg_data_out matches with 1-cycle lag.
- Manual next plus collision: auto_in=0, next_in pulse -> cur 0->1, and cur holds with no pulses for 100 cycles. In auto mode, next_in on the dwell-expiry cycle -> exactly one advance.
- Overlay handshake: in SHOW cur=1, ovl_req=0100 held -> ack[2] on the grant cycle, seg_data=data_2 for 20 cycles, done[2], return to cur=1. The held request is not re-granted until it drops for ≥1 cycle.
- Arbitration and early release: ovl_req=1010 simultaneously -> grant to 1. ovl_req[1] drops after 5 cycles -> done[1] at cycle 5, then requester 3 is granted next.
- Validity loss: during an overlay, src_valid goes from 0010 (cur=1) to 0000 -> on overlay end, done pulses and the state goes to IDLE with blank_out=FF.

Source files
------------

// File: rtl/display_scheduler.sv
// Time-shares the 8-digit seven-segment display among NUM_SRC sources, with granted overlays.
// Optional blinking overlay: define DISPLAY_SCHEDULER_BLINK_EN.
module display_scheduler #(
  parameter int NUM_SRC        = 4,
  parameter int DWELL_CYCLES   = 100_000_000,
  parameter int OVERLAY_CYCLES = 200_000_000,
  parameter int CNT_W          = 28
`ifdef DISPLAY_SCHEDULER_BLINK_EN
  , parameter int BLINK_CYCLES = 25_000_000
`endif
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [32*NUM_SRC-1:0]      src_data_in,
  input  logic [NUM_SRC-1:0]         src_valid_in,
  input  logic                       auto_in,
  input  logic                       next_in,
  input  logic [NUM_SRC-1:0]         ovl_req_in,
  output logic [NUM_SRC-1:0]         ovl_ack_out,
  output logic [NUM_SRC-1:0]         ovl_done_out,
  output logic [31:0]                seg_data_out,
  output logic [7:0]                 blank_out,
  output logic [$clog2(NUM_SRC)-1:0] active_src_out,
  output logic                       overlay_active_out
);
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] OVL_LAST   = CNT_W'(OVERLAY_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, OVERLAY} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    cur, cur_n, ovl_src, ovl_src_n;
  logic [CNT_W-1:0]    dwell_cnt, dwell_n, ovl_cnt, ovl_cnt_n;
  logic [NUM_SRC-1:0]  armed, armed_n, ack_n, done_n, cand;
  logic [IDX_W-1:0]    grant_idx, low_valid;
  logic                any_valid;
  logic [31:0]         seg_n;
  logic [7:0]          blank_n;
  logic [IDX_W-1:0]    active_n;

  // Cyclic search from cur+1; falls back to cur itself when it is the only valid one.
  function automatic logic [IDX_W-1:0] next_valid(input logic [IDX_W-1:0] from,
                                                   input logic [NUM_SRC-1:0] v);
    logic [IDX_W-1:0] r;
    int idx;
    r = from;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(from) + k) % NUM_SRC;
      if (v[idx]) r = IDX_W'(idx);
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_SRC-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  assign any_valid = |src_valid_in;
  assign cand      = ovl_req_in & armed;
  assign grant_idx = lowest(cand);
  assign low_valid = lowest(src_valid_in);

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    ovl_src_n = ovl_src;
    dwell_n   = dwell_cnt;
    ovl_cnt_n = ovl_cnt;
    ack_n     = '0;
    done_n    = '0;
    armed_n   = armed | ~ovl_req_in;
    case (state)
      IDLE, SHOW: begin
        if (|cand) begin
          // Grant wins over next_in / dwell expiry; cur stays put as the saved source.
          state_n          = OVERLAY;
          ovl_src_n        = grant_idx;
          ovl_cnt_n        = '0;
          ack_n[grant_idx] = 1'b1;
        end else if (state == IDLE) begin
          if (any_valid) begin
            state_n = SHOW;
            cur_n   = low_valid;
            dwell_n = '0;
          end
        end else if (!any_valid) begin
          state_n = IDLE;
          dwell_n = '0;
        end else if (!src_valid_in[cur] || next_in || (auto_in && dwell_cnt == DWELL_LAST)) begin
          cur_n   = next_valid(cur, src_valid_in);
          dwell_n = '0;
        end else if (auto_in) begin
          dwell_n = dwell_cnt + CNT_W'(1);
        end else begin
          dwell_n = '0;
        end
      end
      OVERLAY: begin
        if (ovl_cnt == OVL_LAST || !ovl_req_in[ovl_src]) begin
          done_n[ovl_src]  = 1'b1;
          armed_n[ovl_src] = 1'b0;
          dwell_n          = '0;
          if (!any_valid) begin
            state_n = IDLE;
          end else begin
            state_n = SHOW;
            if (!src_valid_in[cur]) cur_n = next_valid(cur, src_valid_in);
          end
        end else begin
          ovl_cnt_n = ovl_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef DISPLAY_SCHEDULER_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);
  logic [CNT_W-1:0] blink_cnt, blink_cnt_n;
  logic             blink_on, blink_on_n;

  // Phase restarts at "lit" on every grant, so only continuing overlay cycles advance it.
  always_comb begin
    blink_cnt_n = '0;
    blink_on_n  = 1'b0;
    if (state == OVERLAY && state_n == OVERLAY) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_on_n = ~blink_on;
      end else begin
        blink_cnt_n = blink_cnt + CNT_W'(1);
        blink_on_n  = blink_on;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_n;
      blink_on  <= blink_on_n;
    end
  end
`endif

  always_comb begin
    seg_n    = '0;
    blank_n  = 8'hFF;
    active_n = cur_n;
    case (state_n)
      SHOW: begin
        seg_n   = src_data_in[32*int'(cur_n) +: 32];
        blank_n = 8'h00;
      end
      OVERLAY: begin
        seg_n    = src_data_in[32*int'(ovl_src_n) +: 32];
        active_n = ovl_src_n;
`ifdef DISPLAY_SCHEDULER_BLINK_EN
        blank_n  = {8{blink_on_n}};
`else
        blank_n  = 8'h00;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= IDLE;
      cur                <= '0;
      ovl_src            <= '0;
      dwell_cnt          <= '0;
      ovl_cnt            <= '0;
      armed              <= '1;
      ovl_ack_out        <= '0;
      ovl_done_out       <= '0;
      seg_data_out       <= '0;
      blank_out          <= 8'hFF;
      active_src_out     <= '0;
      overlay_active_out <= 1'b0;
    end else begin
      state              <= state_n;
      cur                <= cur_n;
      ovl_src            <= ovl_src_n;
      dwell_cnt          <= dwell_n;
      ovl_cnt            <= ovl_cnt_n;
      armed              <= armed_n;
      ovl_ack_out        <= ack_n;
      ovl_done_out       <= done_n;
      seg_data_out       <= seg_n;
      blank_out          <= blank_n;
      active_src_out     <= active_n;
      overlay_active_out <= (state_n == OVERLAY);
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: NUM_SRC=4, DWELL_CYCLES=8, OVERLAY_CYCLES=20.
module tb_display_scheduler;
  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [127:0] src_data_in;
  logic [3:0]   src_valid_in, ovl_req_in, ovl_ack_out, ovl_done_out;
  logic         auto_in, next_in, overlay_active_out;
  logic [31:0]  seg_data_out;
  logic [7:0]   blank_out;
  logic [1:0]   active_src_out;

  int n_chk = 0;
  int n_err = 0;

  display_scheduler #(.NUM_SRC(4), .DWELL_CYCLES(8), .OVERLAY_CYCLES(20), .CNT_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .src_data_in(src_data_in), .src_valid_in(src_valid_in),
    .auto_in(auto_in), .next_in(next_in), .ovl_req_in(ovl_req_in), .ovl_ack_out(ovl_ack_out),
    .ovl_done_out(ovl_done_out), .seg_data_out(seg_data_out), .blank_out(blank_out),
    .active_src_out(active_src_out), .overlay_active_out(overlay_active_out));

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_next();
    next_in = 1'b1;
    step();
    next_in = 1'b0;
  endtask

  function automatic logic [31:0] dat(input int i);
    return 32'h1111_1111 * i;
  endfunction

  logic [3:0] ack_acc;
  int exp_seq[4];

  initial begin
    rst_in = 1'b1;
    src_valid_in = '0; ovl_req_in = '0; auto_in = 1'b0; next_in = 1'b0;
    src_data_in = {dat(3), dat(2), dat(1), dat(0)};
    step();
    check("rst_blank", blank_out, 8'hFF);
    check("rst_ack", ovl_ack_out, 4'h0);
    rst_in = 1'b0;

    // Get into SHOW, then reset asynchronously in mid-cycle
    src_valid_in = 4'b0001;
    step(); step();
    check("pre_rst_blank", blank_out, 8'h00);
    #3 rst_in = 1'b1;
    #1;
    check("async_rst_blank", blank_out, 8'hFF);
    check("async_rst_seg", seg_data_out, 32'h0);
    check("async_rst_active", active_src_out, 2'd0);
    check("async_rst_ovl", overlay_active_out, 1'b0);
    src_valid_in = 4'b0000;
    #1 rst_in = 1'b0;
    repeat (3) step();
    check("idle_blank", blank_out, 8'hFF);
    check("idle_seg", seg_data_out, 32'h0);

    // Auto rotation over valid set {0,1,3}
    src_valid_in = 4'b1011;
    auto_in = 1'b1;
    exp_seq = '{0, 1, 3, 0};
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        check($sformatf("auto_active_%0d_%0d", s, c), active_src_out, exp_seq[s]);
        check($sformatf("auto_seg_%0d_%0d", s, c), seg_data_out, dat(exp_seq[s]));
        check($sformatf("auto_blank_%0d_%0d", s, c), blank_out, 8'h00);
      end
    end
    step();
    check("auto_wrap", active_src_out, 2'd0);

    // Live data follows with one cycle of lag
    src_data_in[31:0] = 32'hCAFE_BABE;
    auto_in = 1'b0;
    step();
    check("seg_follow", seg_data_out, 32'hCAFE_BABE);
    src_data_in[31:0] = dat(0);
    step();

    // Manual mode
    pulse_next();
    check("manual_next", active_src_out, 2'd1);
    repeat (100) step();
    check("manual_hold", active_src_out, 2'd1);
    pulse_next();
    check("manual_skip", active_src_out, 2'd3);
    pulse_next();
    check("manual_wrap", active_src_out, 2'd0);

    // next_in on the dwell-expiry cycle: only one advance
    auto_in = 1'b1;
    repeat (7) step();
    check("coll_pre", active_src_out, 2'd0);
    pulse_next();
    check("coll_single", active_src_out, 2'd1);
    repeat (7) step();
    check("coll_restart", active_src_out, 2'd1);
    step();
    check("coll_next_dwell", active_src_out, 2'd3);

    // Manual back to cur=1
    auto_in = 1'b0;
    step();
    pulse_next(); step();
    pulse_next(); step();
    check("ovl_setup", active_src_out, 2'd1);

    // Overlay handshake with full timeout
    ovl_req_in = 4'b0100;
    step();
    check("ovl_ack", ovl_ack_out, 4'b0100);
    check("ovl_active", overlay_active_out, 1'b1);
    check("ovl_src", active_src_out, 2'd2);
    check("ovl_seg", seg_data_out, dat(2));
    ack_acc = '0;
    for (int c = 1; c < 20; c++) begin
      step();
      ack_acc |= ovl_ack_out;
      check($sformatf("ovl_hold_%0d", c), overlay_active_out, 1'b1);
      check($sformatf("ovl_seg_%0d", c), seg_data_out, dat(2));
      check($sformatf("ovl_nodone_%0d", c), ovl_done_out, 4'h0);
    end
    check("ovl_ack_once", ack_acc, 4'h0);
    step();
    check("ovl_done", ovl_done_out, 4'b0100);
    check("ovl_done_noack", ovl_ack_out, 4'h0);
    check("ovl_return", active_src_out, 2'd1);
    check("ovl_return_seg", seg_data_out, dat(1));
    check("ovl_end_active", overlay_active_out, 1'b0);
    ack_acc = '0;
    repeat (5) begin
      step();
      ack_acc |= ovl_ack_out;
    end
    check("held_no_regrant", ack_acc, 4'h0);
    ovl_req_in = 4'b0000;
    step();
    ovl_req_in = 4'b0100;
    step();
    check("regrant_ack", ovl_ack_out, 4'b0100);
    ovl_req_in = 4'b0000;
    step();
    check("regrant_release", ovl_done_out, 4'b0100);
    check("regrant_ret", active_src_out, 2'd1);

    // Arbitration and early release
    ovl_req_in = 4'b1010;
    step();
    check("arb_ack", ovl_ack_out, 4'b0010);
    check("arb_active", overlay_active_out, 1'b1);
    repeat (4) step();
    check("arb_still", overlay_active_out, 1'b1);
    ovl_req_in = 4'b1000;
    step();
    check("early_done", ovl_done_out, 4'b0010);
    check("early_noack", ovl_ack_out, 4'h0);
    step();
    check("arb_second_ack", ovl_ack_out, 4'b1000);
    check("arb_second_src", active_src_out, 2'd3);
    check("arb_second_seg", seg_data_out, dat(3));
    ovl_req_in = 4'b0000;
    step();
    check("arb_second_done", ovl_done_out, 4'b1000);

    // Validity loss during overlay (requester 2's source is not valid)
    src_valid_in = 4'b0010;
    step();
    ovl_req_in = 4'b0100;
    step();
    check("vl_ack", ovl_ack_out, 4'b0100);
    src_valid_in = 4'b0000;
    repeat (3) step();
    check("vl_seg", seg_data_out, dat(2));
    check("vl_blank", blank_out, 8'h00);
    ovl_req_in = 4'b0000;
    step();
    check("vl_done", ovl_done_out, 4'b0100);
    check("vl_idle_blank", blank_out, 8'hFF);
    check("vl_idle_seg", seg_data_out, 32'h0);
    check("vl_idle_ovl", overlay_active_out, 1'b0);

    // Reset mid-overlay: no done pulse
    src_valid_in = 4'b0010;
    step();
    ovl_req_in = 4'b0001;
    step();
    check("rst_ovl_ack", ovl_ack_out, 4'b0001);
    #3 rst_in = 1'b1;
    ovl_req_in = 4'b0000;
    #1;
    check("rst_ovl_done", ovl_done_out, 4'h0);
    check("rst_ovl_active", overlay_active_out, 1'b0);
    check("rst_ovl_blank", blank_out, 8'hFF);
    step();
    check("rst_ovl_done_after", ovl_done_out, 4'h0);
    rst_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
